// File: rtl/dataselect_pkg.sv
// dataselect_pkg: shared constants and helpers
// for the N-channel data selector slice.
package dataselect_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int next_idx(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_nch.sv
// rr_arbiter_nch: wrapped priority search
// starting at ptr, modulo NCH.
module rr_arbiter_nch #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            enable,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [2*NCH-1:0] req2;
  logic [NCH-1:0]   rot;
  logic [SELW:0]    idx;

  assign req2 = {req, req};
  assign rot  = NCH'(req2 >> ptr);

  // first requester at or after ptr; rot[k] is channel (ptr+k) mod NCH
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= NCH_W)
        idx = idx - NCH_W;
      if (enable && !grant_valid && rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/dataselect_rr_nch.sv
// dataselect_rr_nch: N-channel selector, fixed or
// round-robin, registered output with valid/ready.
module dataselect_rr_nch
  import dataselect_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      ctrl,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  g;
  logic [SELW-1:0]  rr_idx;
  logic             rr_valid;
  logic             fix_valid;
  logic             load_ok;
  logic             rr_en;
  logic             grant;
  logic [WIDTH-1:0] g_data;

  assign load_ok = !out_valid || out_ready;
  assign rr_en   = load_ok && !rst &&
                   (mode == MODE_RR);

  rr_arbiter_nch #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .enable      (rr_en),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // fixed-mode request; an out-of-range ctrl matches no channel
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (ctrl == SELW'(i))
        fix_valid = in_valid[i];
  end

  assign g     = (mode == MODE_RR) ? rr_idx : ctrl;
  assign grant = !rst && load_ok &&
                 ((mode == MODE_RR) ? rr_valid
                                    : fix_valid);

  // one-hot ready and data mux for the granted channel
  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int i = 0; i < NCH; i++)
      if (g == SELW'(i)) begin
        in_ready[i] = grant;
        g_data      = data_in[i*WIDTH +: WIDTH];
      end
  end

  // output register, drain and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (grant) begin
      out_data  <= g_data;
      out_sel   <= g;
      out_valid <= 1'b1;
      if (mode == MODE_RR)
        ptr <= SELW'(next_idx(int'(g), NCH));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dataselect_rr_nch.sv
// tb_dataselect_rr_nch: random + directed stimulus,
// reference model feeding a scoreboard.
module tb_dataselect_rr_nch;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   ctrl;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_valid;
  logic           out_ready;

  dataselect_rr_nch #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .ctrl      (ctrl),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic           rst3;
  logic [3*W-1:0] d3;
  logic [2:0]     v3;
  logic [2:0]     r3;
  logic           m3;
  logic [1:0]     c3;
  logic [W-1:0]   od3;
  logic [1:0]     os3;
  logic           ov3;
  logic           ordy3;

  dataselect_rr_nch #(.WIDTH(W), .NCH(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .data_in   (d3),
    .in_valid  (v3),
    .in_ready  (r3),
    .mode      (m3),
    .ctrl      (c3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_valid (ov3),
    .out_ready (ordy3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] data;
    int           sel;
  } exp_t;

  exp_t         q[$];
  bit           armed = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_sel = 0;
  int           m_ptr = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: grant from the selection rules, push expectations
  always @(negedge clk) begin : model
    int           g;
    int           idx;
    bit           lok;
    logic [N-1:0] er;
    exp_t         e;
    lok = !m_valid || out_ready;
    g   = -1;
    if (!rst && lok) begin
      if (mode) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && in_valid[idx])
            g = idx;
        end
      end else if (in_valid[ctrl]) begin
        g = int'(ctrl);
      end
    end
    er = '0;
    if (g >= 0)
      er[g] = 1'b1;
    if (armed) begin
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, m_valid);
      if (!m_valid) begin
        chk("held_data", out_data, m_data);
        chk("held_sel", out_sel, m_sel);
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      q.delete();
      armed   = 1'b1;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = data_in[g*W +: W];
      m_sel   = g;
      if (mode)
        m_ptr = (g + 1) % N;
      e.data = m_data;
      e.sel  = g;
      q.push_back(e);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // monitor: compare presented word with scoreboard head, pop on accept
  always @(negedge clk) begin : monitor
    if (armed && !rst && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got word %0h expected none",
                 out_data);
      end else begin
        chk("sb_data", out_data, q[0].data);
        chk("sb_sel", out_sel, q[0].sel);
        if (out_ready)
          void'(q.pop_front());
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < N; i++)
      data_in[i*W +: W] = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    data_in   = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    mode      = 1'b1;
    ctrl      = '0;
    rst3      = 1'b1;
    d3        = {32'h3333_0002, 32'h3333_0001,
                 32'h3333_0000};
    v3        = '0;
    m3        = 1'b1;
    c3        = '0;
    ordy3     = 1'b1;
    rand_data();
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    mode = 1'b0;
    ctrl = 2'd2;
    in_valid = 4'b0100;
    data_in[2*W +: W] = 32'hA5A5_0002;
    repeat (2) step();
    ctrl = 2'd1;
    in_valid = 4'b0000;
    repeat (2) step();

    mode = 1'b1;
    in_valid = 4'b1111;
    repeat (8) begin
      rand_data();
      step();
    end

    in_valid = 4'b0100;
    step();
    in_valid = 4'b0011;
    repeat (3) step();

    out_ready = 1'b0;
    in_valid = 4'b1111;
    repeat (5) begin
      rand_data();
      step();
    end
    out_ready = 1'b1;
    repeat (2) step();

    in_valid = 4'b0010;
    step();
    rst = 1'b1;
    in_valid = 4'b1111;
    step();
    rst = 1'b0;
    in_valid = 4'b1010;
    repeat (2) step();
    in_valid = '0;
    step();

    for (int c = 0; c < 3000; c++) begin
      rand_data();
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0)
        mode = ~mode;
      ctrl = S'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("sb_drain", 64'(q.size()), 64'd0);

    rst3 = 1'b0;
    v3   = 3'b100;
    @(negedge clk);
    chk("n3_rdy_ch2", r3, 3'b100);
    step();
    v3 = 3'b111;
    @(negedge clk);
    chk("n3_valid", ov3, 1'b1);
    chk("n3_sel2", os3, 2'd2);
    chk("n3_data2", od3, 32'h3333_0002);
    chk("n3_wrap_rdy", r3, 3'b001);
    step();
    m3 = 1'b0;
    c3 = 2'd3;
    @(negedge clk);
    chk("n3_sel0", os3, 2'd0);
    chk("n3_data0", od3, 32'h3333_0000);
    chk("n3_ctrl_oob", r3, 3'b000);
    step();
    @(negedge clk);
    chk("n3_drain", ov3, 1'b0);
    chk("n3_hold_sel", os3, 2'd0);
    chk("n3_hold_data", od3, 32'h3333_0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
